enc_8b10b_lanes: RTL and testbench
==================================

ENC_8B10B_LANES -- requirements
Module: enc_8b10b_lanes

Interface
REQ-001 Parameter LANES, default 2, number of byte lanes encoded per cycle; legal range 1..4.
REQ-002 Parameter IDLE_EN, default 1, 1 = emit K28.5 idle characters when no input is accepted; 0 = no idle emission.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  input word valid.
REQ-006 in_ready  output  1  block can accept an input word this cycle.
REQ-007 in_data  input  8*LANES  lane i byte at [8i+7:8i], HGFEDCBA order with A at LSB.
REQ-008 in_k  input  LANES  per-lane control-character flag.
REQ-009 rd_load  input  1  load running disparity (RD) from rd_val.
REQ-010 rd_val  input  1  RD value to load: 0 = RD-, 1 = RD+.
REQ-011 out_valid  output  1  output word valid.
REQ-012 out_ready  input  1  downstream accepts the output word.
REQ-013 out_data  output  10*LANES  lane i code at [10i+9:10i], bit order a,b,c,d,e,i,f,g,h,j with a at bit 10i+9.
REQ-014 out_k_err  output  LANES  per-lane illegal-K flag, aligned with out_data.
REQ-015 rd_out  output  1  current stored RD.

Function
REQ-016 Encoding SHALL follow standard 8b/10b (5b/6b + 3b/4b) tables, including the D.x.7 alternate encoding (A7) for x=17,18,20 at RD- and x=11,13,14 at RD+.
REQ-017 Legal K codes: K28.0-K28.7, K23.7, K27.7, K29.7, K30.7; any other byte with in_k=1 SHALL be encoded as K28.5 for the current RD, with that lane's out_k_err=1.
REQ-018 RD chains across lanes within a word: lane 0 uses stored RD, lane i uses RD resulting from lane i-1; stored RD updates to the RD after lane LANES-1.
REQ-019 Within each lane, the 3b/4b sub-block uses the RD resulting from that lane's 5b/6b sub-block.
REQ-020 Handshake: in_ready = ~out_valid | out_ready (single registered output stage, no combinational in_valid->out_valid path).
REQ-021 Input accepted when in_valid & in_ready; encoded word appears on out_data with out_valid=1 on the next cycle (latency 1).
REQ-022 out_data, out_k_err and out_valid SHALL hold stable while out_valid=1 & out_ready=0.
REQ-023 IDLE_EN=1: when in_ready=1 and in_valid=0, the register loads K28.5 on every lane (RD chained per REQ-018), out_valid=1, out_k_err=0; stored RD updates.
REQ-024 IDLE_EN=0: when in_ready=1 and in_valid=0, out_valid becomes 0 and stored RD is unchanged.
REQ-025 Stored RD changes only when the output register loads (accept or idle).
REQ-026 rd_load=1 sets stored RD to rd_val next cycle and has priority over any RD update in the same cycle; a word loaded in that cycle is encoded with the pre-load RD.
REQ-027 rd_out reflects stored RD combinationally from the register.

Reset
REQ-028 While rst_n=0: out_valid=0, out_data=0, out_k_err=0, stored RD=RD- (0).
REQ-029 Reset assertion mid-transfer SHALL discard the held output word; after release, first load uses RD-.
REQ-030 IDLE_EN=1: first idle word SHALL load on the first rising edge after reset release.

Verification
REQ-031 LANES=1, IDLE_EN=0, RD-: in_data=0x00, in_k=0 -> out_data=0x274 next cycle, rd_out stays 0.
REQ-032 LANES=2, RD-: in_data=0xBCBC, in_k=2'b11 -> lane0=0x0FA, lane1=0x305, rd_out=0 afterwards.
REQ-033 LANES=1, RD-: in_data=0xB5 (D21.5), in_k=0 -> out_data=0x2AA, RD unchanged.
REQ-034 LANES=1, RD-: in_data=0x00, in_k=1 -> out_data=0x0FA, out_k_err=1, rd_out=1.
REQ-035 Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_data/rd_out frozen; on out_ready=1, next word accepted and emitted.
REQ-036 IDLE_EN=1, LANES=1, no input after reset -> out_data alternates 0x0FA, 0x305, 0x0FA...; rd_load=1, rd_val=1 -> next idle word 0x305.

Source files
------------

// File: rtl/enc_8b10b_lanes.sv
// enc_8b10b_lanes
// Multi-lane 8b/10b encoder with a single registered output stage.
// Each cycle one word of LANES bytes is encoded; running disparity (RD)
// chains lane 0 -> lane LANES-1 and is stored for the next word.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   in_valid/in_ready/in_data/in_k   input word (8 bits + K flag per lane)
//   rd_load/rd_val   force stored RD (0 = RD-, 1 = RD+)
//   out_valid/out_ready/out_data/out_k_err   encoded word (10 bits per lane,
//                    bit order a..j with a at the lane MSB), illegal-K flags
//   rd_out           stored RD
//
// Handshake (valid/ready): a transfer happens on a rising edge where
// valid & ready are both 1. out_valid and its payload stay stable until
// out_ready; in_ready = ~out_valid | out_ready, so there is no combinational
// path from in_valid to out_valid.
module enc_8b10b_lanes #(
  parameter int LANES   = 2,
  parameter int IDLE_EN = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*LANES-1:0]    in_data,
  input  logic [LANES-1:0]      in_k,
  input  logic                  rd_load,
  input  logic                  rd_val,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [10*LANES-1:0]   out_data,
  output logic [LANES-1:0]      out_k_err,
  output logic                  rd_out
);

  localparam logic [7:0] K28_5 = 8'hBC;

  // Encode one byte. Returns {k_err, rd_after, code[9:0]}.
  // Tables hold the RD- form; 'dep' marks codes whose RD+ form is the
  // complement, 'tog' marks unbalanced codes that flip RD.
  function automatic logic [11:0] enc_lane(input logic [7:0] b, input logic k,
                                           input logic rd_in);
    logic [4:0] x;
    logic [2:0] y;
    logic       err;
    logic [5:0] s6;
    logic       dep6;
    logic       tog6;
    logic       rd_m;
    logic [3:0] s4;
    logic       dep4;
    logic       tog4;
    logic       a7;
    x    = b[4:0];
    y    = b[7:5];
    err  = k & ~((x == 5'd28) |
                 ((y == 3'd7) & ((x == 5'd23) | (x == 5'd27) |
                                 (x == 5'd29) | (x == 5'd30))));
    // An illegal K character is replaced by K28.5.
    if (err) begin
      x = 5'd28;
      y = 3'd5;
    end
    s6   = 6'b000000;
    dep6 = 1'b0;
    case (x)
      5'd0:  begin s6 = 6'b100111; dep6 = 1'b1; end
      5'd1:  begin s6 = 6'b011101; dep6 = 1'b1; end
      5'd2:  begin s6 = 6'b101101; dep6 = 1'b1; end
      5'd3:  s6 = 6'b110001;
      5'd4:  begin s6 = 6'b110101; dep6 = 1'b1; end
      5'd5:  s6 = 6'b101001;
      5'd6:  s6 = 6'b011001;
      5'd7:  begin s6 = 6'b111000; dep6 = 1'b1; end
      5'd8:  begin s6 = 6'b111001; dep6 = 1'b1; end
      5'd9:  s6 = 6'b100101;
      5'd10: s6 = 6'b010101;
      5'd11: s6 = 6'b110100;
      5'd12: s6 = 6'b001101;
      5'd13: s6 = 6'b101100;
      5'd14: s6 = 6'b011100;
      5'd15: begin s6 = 6'b010111; dep6 = 1'b1; end
      5'd16: begin s6 = 6'b011011; dep6 = 1'b1; end
      5'd17: s6 = 6'b100011;
      5'd18: s6 = 6'b010011;
      5'd19: s6 = 6'b110010;
      5'd20: s6 = 6'b001011;
      5'd21: s6 = 6'b101010;
      5'd22: s6 = 6'b011010;
      5'd23: begin s6 = 6'b111010; dep6 = 1'b1; end
      5'd24: begin s6 = 6'b110011; dep6 = 1'b1; end
      5'd25: s6 = 6'b100110;
      5'd26: s6 = 6'b010110;
      5'd27: begin s6 = 6'b110110; dep6 = 1'b1; end
      5'd28: s6 = 6'b001110;
      5'd29: begin s6 = 6'b101110; dep6 = 1'b1; end
      5'd30: begin s6 = 6'b011110; dep6 = 1'b1; end
      default: begin s6 = 6'b101011; dep6 = 1'b1; end
    endcase
    if (k && (x == 5'd28)) begin
      s6   = 6'b001111;
      dep6 = 1'b1;
    end
    // D.7 is balanced but still has two polarities; it never flips RD.
    tog6 = dep6 & ~(~k & (x == 5'd7));
    if (dep6 && rd_in) s6 = ~s6;
    rd_m = rd_in ^ tog6;

    a7   = (~rd_m & ((x == 5'd17) | (x == 5'd18) | (x == 5'd20))) |
           ( rd_m & ((x == 5'd11) | (x == 5'd13) | (x == 5'd14)));
    s4   = 4'b0000;
    dep4 = 1'b0;
    tog4 = 1'b0;
    if (k) begin
      // Every K 3b/4b code is RD dependent; balanced ones keep RD.
      dep4 = 1'b1;
      case (y)
        3'd0:    begin s4 = 4'b1011; tog4 = 1'b1; end
        3'd1:    s4 = 4'b0110;
        3'd2:    s4 = 4'b1010;
        3'd3:    s4 = 4'b1100;
        3'd4:    begin s4 = 4'b1101; tog4 = 1'b1; end
        3'd5:    s4 = 4'b0101;
        3'd6:    s4 = 4'b1001;
        default: begin s4 = 4'b0111; tog4 = 1'b1; end
      endcase
    end else begin
      case (y)
        3'd0:    begin s4 = 4'b1011; dep4 = 1'b1; tog4 = 1'b1; end
        3'd1:    s4 = 4'b1001;
        3'd2:    s4 = 4'b0101;
        3'd3:    begin s4 = 4'b1100; dep4 = 1'b1; end
        3'd4:    begin s4 = 4'b1101; dep4 = 1'b1; tog4 = 1'b1; end
        3'd5:    s4 = 4'b1010;
        3'd6:    s4 = 4'b0110;
        default: begin
          s4   = a7 ? 4'b0111 : 4'b1110;
          dep4 = 1'b1;
          tog4 = 1'b1;
        end
      endcase
    end
    if (dep4 && rd_m) s4 = ~s4;
    return {err, rd_m ^ tog4, s6, s4};
  endfunction

  logic                rd_q;
  logic                rd_next;
  logic                load;
  logic [10*LANES-1:0] enc_data;
  logic [LANES-1:0]    enc_err;

  assign in_ready = ~out_valid | out_ready;
  assign load     = in_ready & (in_valid | (IDLE_EN != 0));
  assign rd_out   = rd_q;

  // Idle words are K28.5 on every lane, chained like normal data.
  always_comb begin
    logic        rd_c;
    logic [7:0]  lane_byte;
    logic        lane_k;
    logic [11:0] r;
    rd_c      = rd_q;
    enc_data  = '0;
    enc_err   = '0;
    lane_byte = K28_5;
    lane_k    = 1'b1;
    r         = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_byte = in_valid ? in_data[8*i +: 8] : K28_5;
      lane_k    = in_valid ? in_k[i] : 1'b1;
      r         = enc_lane(lane_byte, lane_k, rd_c);
      enc_data[10*i +: 10] = r[9:0];
      enc_err[i]           = r[11];
      rd_c                 = r[10];
    end
    rd_next = rd_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_k_err <= '0;
      rd_q      <= 1'b0;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= enc_data;
        out_k_err <= enc_err;
      end else if (in_ready) begin
        out_valid <= 1'b0;
      end
      // A word loaded together with rd_load was encoded with the old RD.
      if (rd_load)   rd_q <= rd_val;
      else if (load) rd_q <= rd_next;
    end
  end

endmodule

// File: tb/tb_enc_8b10b_lanes.sv
// Testbench for enc_8b10b_lanes.
// u2: LANES=2, IDLE_EN=1, random traffic against a reference model.
// u1: LANES=1, IDLE_EN=0 and u3: LANES=1, IDLE_EN=1 for directed vectors.
module tb_enc_8b10b_lanes;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // ---------------- DUT signals ----------------
  logic        in_valid1, in_ready1, rd_load1, rd_val1, out_valid1, out_ready1, rd_out1;
  logic [7:0]  in_data1;
  logic [0:0]  in_k1, out_k_err1;
  logic [9:0]  out_data1;

  logic        in_valid2, in_ready2, rd_load2, rd_val2, out_valid2, out_ready2, rd_out2;
  logic [15:0] in_data2;
  logic [1:0]  in_k2, out_k_err2;
  logic [19:0] out_data2;

  logic        in_valid3, in_ready3, rd_load3, rd_val3, out_valid3, out_ready3, rd_out3;
  logic [7:0]  in_data3;
  logic [0:0]  in_k3, out_k_err3;
  logic [9:0]  out_data3;

  enc_8b10b_lanes #(.LANES(1), .IDLE_EN(0)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data1), .in_k(in_k1), .rd_load(rd_load1), .rd_val(rd_val1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .out_k_err(out_k_err1), .rd_out(rd_out1));

  enc_8b10b_lanes #(.LANES(2), .IDLE_EN(1)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_data(in_data2), .in_k(in_k2), .rd_load(rd_load2), .rd_val(rd_val2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
    .out_k_err(out_k_err2), .rd_out(rd_out2));

  enc_8b10b_lanes #(.LANES(1), .IDLE_EN(1)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_data(in_data3), .in_k(in_k3), .rd_load(rd_load3), .rd_val(rd_val3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
    .out_k_err(out_k_err3), .rd_out(rd_out3));

  // ---------------- checking task ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // 6b codes (abcdei) as listed for RD-, and 3b/4b codes (fghj) for RD-.
  logic [5:0] six_m [32];
  logic [3:0] d4_m  [8];
  logic [3:0] k4_m  [8];
  logic [7:0] legal_k [12];

  initial begin
    six_m = '{6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001,
              6'b011001, 6'b111000, 6'b111001, 6'b100101, 6'b010101, 6'b110100,
              6'b001101, 6'b101100, 6'b011100, 6'b010111, 6'b011011, 6'b100011,
              6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
              6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110,
              6'b011110, 6'b101011};
    d4_m  = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
    k4_m  = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};
    legal_k = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
                8'hF7, 8'hFB, 8'hFD, 8'hFE};
  end

  // Disparity rule: a sub-block with more ones than zeros leaves RD+, fewer
  // leaves RD-, balanced keeps RD. At RD+ the RD- form is complemented when
  // it is unbalanced, plus the balanced-but-polar D.7 / x.3 / K forms.
  function automatic void ref_lane(input logic [7:0] b, input logic k, input logic rd_in,
                                   output logic [9:0] code, output logic err,
                                   output logic rd_o);
    int x, y;
    logic [5:0] six;
    logic [3:0] four;
    logic rd_mid, legal, a7;
    x = int'(b[4:0]);
    y = int'(b[7:5]);
    legal = (x == 28) || (y == 7 && (x == 23 || x == 27 || x == 29 || x == 30));
    err = k && !legal;
    if (err) begin x = 28; y = 5; end
    six = (k && x == 28) ? 6'b001111 : six_m[x];
    if (rd_in && ($countones(six) != 3 || (!k && x == 7))) six = ~six;
    rd_mid = ($countones(six) == 3) ? rd_in : ($countones(six) > 3);
    if (k) begin
      four = rd_mid ? ~k4_m[y] : k4_m[y];
    end else if (y == 7) begin
      a7 = (!rd_mid && (x == 17 || x == 18 || x == 20)) ||
           ( rd_mid && (x == 11 || x == 13 || x == 14));
      four = a7 ? 4'b0111 : 4'b1110;
      if (rd_mid) four = ~four;
    end else begin
      four = d4_m[y];
      if (rd_mid && ($countones(four) != 2 || y == 3)) four = ~four;
    end
    rd_o = ($countones(four) == 2) ? rd_mid : ($countones(four) > 2);
    code = {six, four};
  endfunction

  // Model of u2 output register state after the next rising edge.
  logic        m_valid;
  logic [19:0] m_data;
  logic [1:0]  m_err;
  logic        m_rd;
  logic        m_ready;

  task automatic model_step2();
    logic [9:0] c;
    logic e, r;
    logic [7:0] b;
    logic kk;
    r = m_rd;
    m_ready = !m_valid || out_ready2;
    if (m_ready) begin
      for (int i = 0; i < 2; i++) begin
        b  = in_valid2 ? in_data2[8*i +: 8] : 8'hBC;
        kk = in_valid2 ? in_k2[i] : 1'b1;
        ref_lane(b, kk, r, c, e, r);
        m_data[10*i +: 10] = c;
        m_err[i] = e;
      end
      m_valid = 1'b1;
    end
    if (rd_load2)     m_rd = rd_val2;
    else if (m_ready) m_rd = r;
  endtask

  task automatic drive_rand2();
    logic [7:0] b;
    in_valid2  = ($urandom_range(0, 3) != 0);
    out_ready2 = ($urandom_range(0, 3) != 0);
    rd_load2   = ($urandom_range(0, 15) == 0);
    rd_val2    = 1'($urandom_range(0, 1));
    for (int i = 0; i < 2; i++) begin
      in_k2[i] = ($urandom_range(0, 3) == 0);
      b = 8'($urandom_range(0, 255));
      if (in_k2[i] && $urandom_range(0, 3) != 0) b = legal_k[$urandom_range(0, 11)];
      in_data2[8*i +: 8] = b;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    in_valid1 = 0; in_data1 = 0; in_k1 = 0; rd_load1 = 0; rd_val1 = 0; out_ready1 = 1;
    in_valid2 = 0; in_data2 = 0; in_k2 = 0; rd_load2 = 0; rd_val2 = 0; out_ready2 = 1;
    in_valid3 = 0; in_data3 = 0; in_k3 = 0; rd_load3 = 0; rd_val3 = 0; out_ready3 = 1;
    m_valid = 0; m_data = 0; m_err = 0; m_rd = 0; m_ready = 1;

    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(out_valid2), 32'd0);
    chk("rst_data",  32'(out_data2),  32'd0);
    chk("rst_kerr",  32'(out_k_err2), 32'd0);
    chk("rst_rd",    32'(rd_out2),    32'd0);

    // Release with no input: the first edge must already load an idle word.
    rst_n = 1'b1;
    out_ready2 = 1'b0;
    model_step2();

    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      chk("r_valid", 32'(out_valid2), 32'(m_valid));
      if (m_valid) begin
        chk("r_data", 32'(out_data2),  32'(m_data));
        chk("r_kerr", 32'(out_k_err2), 32'(m_err));
      end
      chk("r_rd", 32'(rd_out2), 32'(m_rd));
      drive_rand2();
      #1;
      chk("r_ready", 32'(in_ready2), 32'(!m_valid || out_ready2));
      model_step2();
    end

    // ---------------- directed vectors ----------------
    @(negedge clk);
    out_ready2 = 1'b0;
    #1;
    rst_n = 1'b0;
    in_valid1 = 1; in_data1 = 8'h00;   in_k1 = 1'b0; out_ready1 = 1; rd_load1 = 0;
    in_valid2 = 1; in_data2 = 16'hBCBC; in_k2 = 2'b11; out_ready2 = 1; rd_load2 = 0;
    in_valid3 = 0; out_ready3 = 1; rd_load3 = 0; rd_val3 = 0;
    #1;
    chk("rst2_valid", 32'(out_valid2), 32'd0);
    chk("rst2_data",  32'(out_data2),  32'd0);
    chk("rst2_rd",    32'(rd_out2),    32'd0);
    chk("rst1_valid", 32'(out_valid1), 32'd0);
    chk("rst3_valid", 32'(out_valid3), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("d00_data",   32'(out_data1),  32'h274);
    chk("d00_valid",  32'(out_valid1), 32'd1);
    chk("d00_rd",     32'(rd_out1),    32'd0);
    chk("bcbc_data",  32'(out_data2),  32'hC14FA);
    chk("bcbc_kerr",  32'(out_k_err2), 32'd0);
    chk("bcbc_rd",    32'(rd_out2),    32'd0);
    chk("idle1_data", 32'(out_data3),  32'h0FA);
    chk("idle1_rd",   32'(rd_out3),    32'd1);
    in_data1 = 8'hB5; in_valid2 = 0;

    @(negedge clk);
    chk("d215_data",  32'(out_data1), 32'h2AA);
    chk("d215_rd",    32'(rd_out1),   32'd0);
    chk("idle2_data", 32'(out_data3), 32'h305);
    chk("idle2_rd",   32'(rd_out3),   32'd0);
    in_data1 = 8'h00; in_k1 = 1'b1;

    @(negedge clk);
    chk("kbad_data",  32'(out_data1),  32'h0FA);
    chk("kbad_kerr",  32'(out_k_err1), 32'd1);
    chk("kbad_rd",    32'(rd_out1),    32'd1);
    chk("idle3_data", 32'(out_data3),  32'h0FA);
    in_k1 = 1'b0; out_ready1 = 1'b0; rd_load3 = 1'b1; rd_val3 = 1'b1;

    for (int h = 0; h < 3; h++) begin
      #1;
      chk("bp_ready", 32'(in_ready1), 32'd0);
      @(negedge clk);
      chk("bp_data",  32'(out_data1),  32'h0FA);
      chk("bp_kerr",  32'(out_k_err1), 32'd1);
      chk("bp_valid", 32'(out_valid1), 32'd1);
      chk("bp_rd",    32'(rd_out1),    32'd1);
      if (h == 0) begin
        chk("rdld_data", 32'(out_data3), 32'h305);
        chk("rdld_rd",   32'(rd_out3),   32'd1);
        rd_load3 = 1'b0;
      end
      if (h == 1) begin
        chk("rdld_next", 32'(out_data3), 32'h305);
        chk("rdld_rd2",  32'(rd_out3),   32'd0);
      end
    end

    out_ready1 = 1'b1;
    #1;
    chk("bp_release", 32'(in_ready1), 32'd1);
    @(negedge clk);
    chk("d00p_data", 32'(out_data1),  32'h18B);
    chk("d00p_kerr", 32'(out_k_err1), 32'd0);
    chk("d00p_rd",   32'(rd_out1),    32'd1);
    in_valid1 = 1'b0;
    @(negedge clk);
    chk("noidle_valid", 32'(out_valid1), 32'd0);
    chk("noidle_rd",    32'(rd_out1),    32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
